// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one slow-memory line port between the I-cache and D-cache miss and
//   write-back interfaces. One side is granted at a time. Its read, write, addr
//   and wdata go to the memory, and mem_ready is returned only to that side.
//   rdata is broadcast to both sides. Contention is resolved round-robin.
//   A sticky err flag is raised when a grant waits TIMEOUT cycles for mem_ready.
// Ports
//   clk, rst                   rising-edge clock; asynchronous active-high reset
//   i_read/i_write/i_addr/i_wdata, i_ready   I-side request and completion pulse
//   d_read/d_write/d_addr/d_wdata, d_ready   D-side request and completion pulse
//   rdata                      mem_rdata, broadcast to both sides
//   mem_read/mem_write/mem_addr/mem_wdata    toward slow memory
//   mem_rdata/mem_ready        from slow memory
//   gnt_i, gnt_d               current grant
//   err                        sticky timeout flag
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 28,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned CNT_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              gnt_i,
  output logic              gnt_d,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic             last_d_q, last_d_d;   // 1 when the most recent grant went to D
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             req_i, req_d;

  assign req_i = i_read | i_write;
  assign req_d = d_read | d_write;

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_i && req_d) begin
          state_d  = last_d_q ? GNT_I : GNT_D;
          last_d_d = ~last_d_q;
        end else if (req_i) begin
          state_d  = GNT_I;
          last_d_d = 1'b0;
        end else if (req_d) begin
          state_d  = GNT_D;
          last_d_d = 1'b1;
        end
      end
      GNT_I, GNT_D: begin
        // Saturating wait counter; with TIMEOUT==0 it stays at 0.
        if (!mem_ready && (cnt_q != CNT_MAX)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (mem_ready || ((state_q == GNT_I) ? !req_i : !req_d)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    err_d = err_q | ((TIMEOUT != 0) && (cnt_d == CNT_MAX));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Data path is a mux on the state register, so mem_ready reaches x_ready in
  // the same cycle and a reset clears every control output at once.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    unique case (state_q)
      GNT_I: begin
        mem_write = i_write;
        mem_read  = i_read & ~i_write;
        mem_addr  = i_addr;
        mem_wdata = i_wdata;
        i_ready   = mem_ready;
      end
      GNT_D: begin
        mem_write = d_write;
        mem_read  = d_read & ~d_write;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_ready   = mem_ready;
      end
      default: ;
    endcase
  end

  assign gnt_i = (state_q == GNT_I);
  assign gnt_d = (state_q == GNT_D);
  assign err   = err_q;
  assign rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned AW = 28;
  localparam int unsigned DW = 128;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, i_write, d_read, d_write;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] i_wdata, d_wdata;
  logic          i_ready, d_ready;
  logic [DW-1:0] rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          gnt_i, gnt_d, err;

  mem_port_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO),
    .CNT_W  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_read   (i_read),
    .i_write  (i_write),
    .i_addr   (i_addr),
    .i_wdata  (i_wdata),
    .i_ready  (i_ready),
    .d_read   (d_read),
    .d_write  (d_write),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ready  (d_ready),
    .rdata    (rdata),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .gnt_i    (gnt_i),
    .gnt_d    (gnt_d),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: who owns the port (0 none, 1 I, 2 D), who was served
  // last, how long the current owner has waited, and the sticky error.
  int owner;
  bit last_d;
  int wait_cnt;
  bit err_m;
  bit exp_ir, exp_dr;

  task automatic model_reset();
    owner    = 0;
    last_d   = 1'b0;
    wait_cnt = 0;
    err_m    = 1'b0;
  endtask

  task automatic model_update();
    bit ri, rd, req;
    ri = i_read | i_write;
    rd = d_read | d_write;
    if (owner == 0) begin
      if (ri && rd)  owner = last_d ? 1 : 2;
      else if (ri)   owner = 1;
      else if (rd)   owner = 2;
      if (owner != 0) last_d = (owner == 2);
      wait_cnt = 0;
    end else begin
      req = (owner == 1) ? ri : rd;
      if (!mem_ready && wait_cnt < TO) wait_cnt++;
      if (TO != 0 && wait_cnt == TO) err_m = 1'b1;
      if (mem_ready || !req) owner = 0;
    end
  endtask

  // Mid-cycle comparison of every output against the model.
  task automatic eval();
    logic          e_rd, e_wr;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    #4;
    e_rd = 0; e_wr = 0; e_addr = '0; e_wd = '0; exp_ir = 0; exp_dr = 0;
    if (owner == 1) begin
      e_wr = i_write; e_rd = i_read && !i_write; e_addr = i_addr; e_wd = i_wdata;
      exp_ir = mem_ready;
    end else if (owner == 2) begin
      e_wr = d_write; e_rd = d_read && !d_write; e_addr = d_addr; e_wd = d_wdata;
      exp_dr = mem_ready;
    end
    check("gnt_i", DW'(gnt_i), DW'(owner == 1));
    check("gnt_d", DW'(gnt_d), DW'(owner == 2));
    check("mem_read", DW'(mem_read), DW'(e_rd));
    check("mem_write", DW'(mem_write), DW'(e_wr));
    check("mem_addr", DW'(mem_addr), DW'(e_addr));
    check("mem_wdata", mem_wdata, e_wd);
    check("i_ready", DW'(i_ready), DW'(exp_ir));
    check("d_ready", DW'(d_ready), DW'(exp_dr));
    check("err", DW'(err), DW'(err_m));
    check("rdata", rdata, mem_rdata);
  endtask

  task automatic adv();
    @(posedge clk);
    if (rst) model_reset();
    else     model_update();
    #1;
  endtask

  task automatic clear_inputs();
    i_read = 0; i_write = 0; d_read = 0; d_write = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    eval();
    adv();
    rst = 1'b0;
  endtask

  bit            act [2];
  bit            s_rd [2];
  bit            s_wr [2];
  logic [AW-1:0] s_addr [2];
  logic [DW-1:0] s_wd [2];
  bit            rdy_prev [2];
  int            kind;

  initial begin
    clear_inputs();
    i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0; mem_rdata = '0;
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // 1: I read, memory answers in the fifth grant cycle
    i_read = 1; i_addr = 28'h0000010;
    eval();
    check("t1_req_cycle_read", DW'(mem_read), DW'(0));
    adv();
    for (int k = 0; k < 5; k++) begin
      mem_ready = (k == 4);
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      eval();
      check("t1_mem_read", DW'(mem_read), DW'(1));
      check("t1_i_ready", DW'(i_ready), DW'(k == 4));
      check("t1_d_ready", DW'(d_ready), DW'(0));
      adv();
    end
    clear_inputs();
    eval();
    check("t1_back_idle", DW'(gnt_i), DW'(0));
    adv();

    // 2: contention after reset, D first then I after one idle cycle
    do_reset();
    i_read = 1; d_read = 1;
    eval(); adv();
    mem_ready = 1;
    eval();
    check("t2_d_first", DW'(gnt_d), DW'(1));
    check("t2_d_ready", DW'(d_ready), DW'(1));
    check("t2_no_i_ready", DW'(i_ready), DW'(0));
    adv();
    d_read = 0; mem_ready = 0;
    eval();
    check("t2_gap_i", DW'(gnt_i), DW'(0));
    check("t2_gap_d", DW'(gnt_d), DW'(0));
    adv();
    mem_ready = 1;
    eval();
    check("t2_i_second", DW'(gnt_i), DW'(1));
    adv();
    i_read = 0; mem_ready = 0;
    eval(); adv();
    i_read = 1; d_read = 1;
    eval(); adv();
    eval();
    check("t2_alt_d", DW'(gnt_d), DW'(1));
    clear_inputs();
    adv(); eval(); adv();

    // 3: D write forwarding
    d_write = 1; d_addr = 28'h0000020;
    d_wdata = 128'hDEADBEEF_0123_4567_89AB_CDEF_0000_1111;
    eval(); adv();
    mem_ready = 1;
    eval();
    check("t3_write", DW'(mem_write), DW'(1));
    check("t3_read", DW'(mem_read), DW'(0));
    check("t3_addr", DW'(mem_addr), DW'(28'h0000020));
    check("t3_wdata", mem_wdata, 128'hDEADBEEF_0123_4567_89AB_CDEF_0000_1111);
    adv();
    clear_inputs();
    eval(); adv();

    // 4: timeout with mem_ready held low
    do_reset();
    i_read = 1; i_addr = 28'h0ABCDEF;
    eval(); adv();
    for (int k = 1; k <= 10; k++) begin
      eval();
      check("t4_gnt_hold", DW'(gnt_i), DW'(1));
      check("t4_err", DW'(err), DW'(k > 8));
      adv();
    end
    mem_ready = 1;
    eval();
    check("t4_late_ready", DW'(i_ready), DW'(1));
    adv();
    clear_inputs();
    eval();
    check("t4_err_sticky", DW'(err), DW'(1));
    adv();
    do_reset();
    eval();
    check("t4_err_cleared", DW'(err), DW'(0));
    adv();

    // 5: reset asserted mid-cycle during a D grant
    d_write = 1; d_addr = 28'h0000040;
    eval(); adv();
    eval();
    check("t5_gnt_d", DW'(gnt_d), DW'(1));
    mem_ready = 1;
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check("t5_write_drop", DW'(mem_write), DW'(0));
    check("t5_read_drop", DW'(mem_read), DW'(0));
    check("t5_gnt_drop", DW'(gnt_d), DW'(0));
    check("t5_no_d_ready", DW'(d_ready), DW'(0));
    adv();
    rst = 1'b0;
    clear_inputs();
    i_read = 1; d_read = 1;
    eval(); adv();
    eval();
    check("t5_d_after_rst", DW'(gnt_d), DW'(1));
    clear_inputs();
    adv(); eval(); adv();

    // 6: mem_ready while idle, dual read+write on I
    mem_ready = 1;
    eval();
    check("t6_idle_i_ready", DW'(i_ready), DW'(0));
    check("t6_idle_d_ready", DW'(d_ready), DW'(0));
    adv();
    mem_ready = 0; i_read = 1; i_write = 1; i_wdata = 128'h1;
    eval(); adv();
    mem_ready = 1;
    eval();
    check("t6_dual_write", DW'(mem_write), DW'(1));
    check("t6_dual_read", DW'(mem_read), DW'(0));
    adv();
    clear_inputs();
    eval(); adv();

    // Randomized traffic against the model
    do_reset();
    for (int s = 0; s < 2; s++) begin
      act[s] = 0; s_rd[s] = 0; s_wr[s] = 0; rdy_prev[s] = 0;
      s_addr[s] = '0; s_wd[s] = '0;
    end
    for (int n = 0; n < 2000; n++) begin
      for (int s = 0; s < 2; s++) begin
        if (act[s]) begin
          if (rdy_prev[s] || $urandom_range(0, 49) == 0) begin
            act[s] = 0; s_rd[s] = 0; s_wr[s] = 0;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          act[s] = 1;
          kind = $urandom_range(0, 2);
          s_rd[s] = (kind != 1);
          s_wr[s] = (kind != 0);
          s_addr[s] = AW'($urandom);
          s_wd[s] = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      i_read = s_rd[0]; i_write = s_wr[0]; i_addr = s_addr[0]; i_wdata = s_wd[0];
      d_read = s_rd[1]; d_write = s_wr[1]; d_addr = s_addr[1]; d_wdata = s_wd[1];
      mem_ready = ($urandom_range(0, 3) == 0);
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      eval();
      rdy_prev[0] = exp_ir;
      rdy_prev[1] = exp_dr;
      adv();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
